seq_counter_gen: RTL and testbench

Parametrised, multi-mode sequence counter. Next generation of the team's fixed 4-bit ring/shift counter: it generalises width and adds run-time selectable modes, direction, enable, parallel load and a terminal-count flag. Used as the standard counter/pattern source under `top`-level lab designs and as a stimulus generator in benches.

---
 rtl/seq_gen_pkg.sv | 86 ++++++++
 rtl/seq_counter_gen_next.sv | 46 ++++
 rtl/seq_counter_gen.sv | 75 +++++++
 tb/tb_seq_counter_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared constants, word type and next-state helpers
// for the sequence counter family.
package seq_gen_pkg;

  localparam logic [1:0] MODE_BIN  = 2'b00;
  localparam logic [1:0] MODE_RING = 2'b01;
  localparam logic [1:0] MODE_JOHN = 2'b10;
  localparam logic [1:0] MODE_LFSR = 2'b11;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int unsigned MAXW = 32;

  typedef logic [MAXW-1:0] word_t;

  function automatic word_t wmask(
    input int unsigned w
  );
    if (w >= MAXW) return '1;
    return (word_t'(1) << w) - word_t'(1);
  endfunction

  function automatic word_t init_val(
    input logic [1:0] mode,
    input word_t      seed
  );
    word_t v;
    v = '0;
    unique case (mode)
      MODE_RING: v = word_t'(1);
      MODE_LFSR: v = seed;
      default:   v = '0;
    endcase
    return v;
  endfunction

  // Helpers work on a full 32-bit word; callers
  // pass the live width and keep the low bits.
  function automatic word_t step_val(
    input word_t       q,
    input logic [1:0]  mode,
    input logic        dir,
    input int unsigned w,
    input logic [32:0] modulus,
    input word_t       taps
  );
    word_t       m;
    word_t       top;
    word_t       r;
    logic [32:0] qx;
    logic [32:0] lim;
    m   = wmask(w);
    top = word_t'(1) << (w - 1);
    qx  = {1'b0, q};
    lim = modulus - 33'd1;
    r   = q;
    unique case (mode)
      MODE_BIN: begin
        if (dir == DIR_UP)
          r = (qx >= lim) ? '0 : q + word_t'(1);
        else if (q == '0 || qx >= modulus)
          r = lim[31:0];
        else
          r = q - word_t'(1);
      end
      MODE_RING: begin
        if (dir == DIR_UP)
          r = (q << 1)
            | (((q & top) != '0) ? word_t'(1) : '0);
        else
          r = (q >> 1) | (q[0] ? top : '0);
      end
      MODE_JOHN: begin
        if (dir == DIR_UP)
          r = (q << 1)
            | (((q & top) == '0) ? word_t'(1) : '0);
        else
          r = (q >> 1) | (q[0] ? '0 : top);
      end
      default: r = (q >> 1) ^ (q[0] ? taps : '0);
    endcase
    return r & m;
  endfunction

endpackage

// File: rtl/seq_counter_gen_next.sv
// Combinational next-state and terminal-count logic,
// shared with the multi-channel counter.
module seq_next_state
  import seq_gen_pkg::*;
#(
  parameter int unsigned       WIDTH   = 4,
  parameter logic [32:0]       MODULUS = 33'd10,
  parameter logic [WIDTH-1:0]  SEED    = WIDTH'(1),
  parameter logic [WIDTH-1:0]  TAPS    = WIDTH'(4'b1100)
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [1:0]       mode_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] q_nxt_o,
  output logic             tc_o
);

  word_t       q_w;
  word_t       nxt_w;
  word_t       hi_w;
  logic [32:0] lim;

  always_comb begin
    q_w   = word_t'(q_i);
    nxt_w = step_val(q_w, mode_i, dir_i, WIDTH,
                     MODULUS, word_t'(TAPS));
    hi_w  = word_t'(1) << (WIDTH - 1);
    lim   = MODULUS - 33'd1;
    tc_o  = 1'b0;
    unique case (mode_i)
      MODE_BIN:
        tc_o = (dir_i == DIR_UP)
             ? ({1'b0, q_w} >= lim)
             : (q_w == '0);
      MODE_RING, MODE_JOHN:
        tc_o = (dir_i == DIR_UP)
             ? (q_w == hi_w)
             : (q_w == word_t'(1));
      default:
        tc_o = (nxt_w == word_t'(SEED));
    endcase
  end

  assign q_nxt_o = nxt_w[WIDTH-1:0];

endmodule

// File: rtl/seq_counter_gen.sv
// Multi-mode sequence counter: binary, ring,
// Johnson and LFSR with load and terminal count.
module seq_counter_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned       WIDTH   = 4,
  parameter logic [32:0]       MODULUS = 33'd10,
  parameter logic [WIDTH-1:0]  SEED    = WIDTH'(1),
  parameter logic [WIDTH-1:0]  TAPS    = WIDTH'(4'b1100)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             DIR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [1:0]       mode_q;
  logic [1:0]       mode_d;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] init_v;
  word_t            init_w;
  logic             unused_init;

  seq_next_state #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SEED    (SEED),
    .TAPS    (TAPS)
  ) u_next (
    .q_i     (q_q),
    .mode_i  (MODE),
    .dir_i   (DIR),
    .q_nxt_o (nxt),
    .tc_o    (TC)
  );

  assign unused_init = ^init_w;

  // Zero loads in ring/LFSR would lock up, so
  // they fall back to the mode's init value.
  always_comb begin
    init_w = init_val(MODE, word_t'(SEED));
    init_v = init_w[WIDTH-1:0];
    mode_d = MODE;
    q_d    = q_q;
    if (MODE != mode_q)
      q_d = init_v;
    else if (LOAD)
      q_d = (D == '0 && (MODE == MODE_RING ||
                         MODE == MODE_LFSR))
          ? init_v : D;
    else if (EN)
      q_d = nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q    <= init_v;
      mode_q <= MODE;
    end else begin
      q_q    <= q_d;
      mode_q <= mode_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_seq_counter_gen.sv
// Scoreboard bench for seq_counter_gen against an
// arithmetic reference model of each sequence mode.
module tb_seq_counter_gen;

  localparam int unsigned W      = 4;
  localparam int unsigned P      = 16;
  localparam int unsigned M      = 10;
  localparam int unsigned SEED_V = 1;
  localparam int unsigned TAPS_V = 12;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic [1:0] MODE = 2'b00;
  logic       DIR = 1'b0;
  logic       LOAD = 1'b0;
  logic [3:0] D = 4'd0;
  logic [3:0] Q;
  logic       TC;

  always #5 CLK = ~CLK;

  seq_counter_gen #(
    .WIDTH   (W),
    .MODULUS (33'd10),
    .SEED    (4'd1),
    .TAPS    (4'b1100)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .MODE (MODE),
    .DIR  (DIR),
    .LOAD (LOAD),
    .D    (D),
    .Q    (Q),
    .TC   (TC)
  );

  int          errors = 0;
  int          checks = 0;
  int unsigned exp_q[$];
  bit          exp_tc[$];
  string       exp_name[$];
  int unsigned m_q = 0;
  int unsigned m_mode = 0;

  function automatic int unsigned m_init(
    input int unsigned mode
  );
    if (mode == 1) return 1;
    if (mode == 3) return SEED_V;
    return 0;
  endfunction

  function automatic int unsigned m_step(
    input int unsigned q,
    input int unsigned mode,
    input bit dir
  );
    case (mode)
      0: if (!dir) return (q >= M - 1) ? 0 : q + 1;
         else return (q == 0 || q >= M) ? M - 1 : q - 1;
      1: if (!dir) return (q * 2) % P + ((q >= P / 2) ? 1 : 0);
         else return q / 2 + (q % 2) * (P / 2);
      2: if (!dir) return (q * 2) % P + ((q >= P / 2) ? 0 : 1);
         else return q / 2 + ((q % 2 == 0) ? P / 2 : 0);
      default: return (q / 2) ^ ((q % 2 == 1) ? TAPS_V : 0);
    endcase
  endfunction

  function automatic bit m_tc(
    input int unsigned q,
    input int unsigned mode,
    input bit dir
  );
    case (mode)
      0: return dir ? (q == 0) : (q >= M - 1);
      1, 2: return dir ? (q == 1) : (q == P / 2);
      default: return m_step(q, 3, dir) == SEED_V;
    endcase
  endfunction

  task automatic edge_step(
    input bit          rst,
    input bit          en,
    input int unsigned mode,
    input bit          dir,
    input bit          load,
    input int unsigned d,
    input string       name
  );
    logic [1:0] mv;
    logic [3:0] dv;
    mv = mode[1:0];
    dv = d[3:0];
    @(negedge CLK);
    RST  = rst;
    EN   = en;
    MODE = mv;
    DIR  = dir;
    LOAD = load;
    D    = dv;
    if (rst || mode != m_mode) begin
      m_q    = m_init(mode);
      m_mode = mode;
    end else if (load) begin
      if (d == 0 && (mode == 1 || mode == 3))
        m_q = m_init(mode);
      else
        m_q = d % P;
    end else if (en) begin
      m_q = m_step(m_q, mode, dir);
    end
    exp_q.push_back(m_q);
    exp_tc.push_back(m_tc(m_q, mode, dir));
    exp_name.push_back(name);
  endtask

  initial begin : monitor
    int unsigned eq;
    bit          et;
    string       en;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        eq = exp_q.pop_front();
        et = exp_tc.pop_front();
        en = exp_name.pop_front();
        checks++;
        if (Q !== eq[3:0] || TC !== et) begin
          errors++;
          $display("FAIL %s: got Q=%b TC=%b want Q=%b TC=%b",
                   en, Q, TC, eq[3:0], et);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned cm;
    bit          cd;
    edge_step(1, 0, 0, 0, 0, 0, "bin_rst");
    repeat (10) edge_step(0, 1, 0, 0, 0, 0, "bin_up");
    edge_step(1, 0, 0, 1, 0, 0, "bin_dn_rst");
    edge_step(0, 1, 0, 1, 0, 0, "bin_dn_wrap");
    edge_step(0, 1, 0, 1, 1, 12, "bin_load12");
    edge_step(0, 1, 0, 1, 0, 0, "bin_dn_over");
    edge_step(0, 1, 0, 0, 0, 0, "bin_dir_flip");
    edge_step(1, 0, 1, 0, 0, 0, "ring_rst");
    repeat (4) edge_step(0, 1, 1, 0, 0, 0, "ring_up");
    edge_step(0, 1, 1, 1, 0, 0, "ring_dn");
    edge_step(0, 1, 1, 1, 1, 0, "ring_load0");
    edge_step(1, 0, 2, 0, 0, 0, "john_rst");
    repeat (8) edge_step(0, 1, 2, 0, 0, 0, "john_up");
    edge_step(0, 1, 2, 0, 0, 0, "john_up2");
    repeat (5) edge_step(0, 0, 2, 0, 0, 0, "john_hold");
    repeat (3) edge_step(0, 1, 2, 1, 0, 0, "john_dn");
    edge_step(0, 0, 2, 0, 1, 0, "john_load0");
    edge_step(1, 0, 3, 0, 0, 0, "lfsr_rst");
    repeat (15) edge_step(0, 1, 3, 0, 0, 0, "lfsr_step");
    edge_step(0, 0, 3, 0, 1, 0, "lfsr_load0");
    edge_step(1, 0, 0, 0, 0, 0, "sw_rst");
    repeat (5) edge_step(0, 1, 0, 0, 0, 0, "sw_count");
    edge_step(0, 1, 1, 0, 1, 9, "sw_reinit");
    edge_step(1, 1, 1, 0, 1, 6, "rst_over_load");
    cm = 1;
    cd = 0;
    repeat (400) begin
      if ($urandom_range(15) == 0) cm = $urandom_range(3);
      if ($urandom_range(7) == 0) cd = ~cd;
      edge_step($urandom_range(39) == 0,
                $urandom_range(3) != 0,
                cm, cd,
                $urandom_range(7) == 0,
                $urandom_range(15),
                "random");
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge CLK);
    #3;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0",
               exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
